// File: rtl/stream_fifo_if.sv
// Valid/ready stream bundle for stream_fifo: write side, read side and fill-level status.
// The slave modport is the FIFO; the master modport is its producer/consumer environment.
interface stream_fifo_if #(
  parameter int ADDR_LENGTH = 4,
  parameter int WORD_LENGTH = 8
);
  logic [WORD_LENGTH-1:0] i_data_in;
  logic                   i_data_in_valid;
  logic                   o_ready_in;
  logic [WORD_LENGTH-1:0] o_data_out;
  logic                   o_data_out_valid;
  logic                   i_ready_out;
  logic                   o_full;
  logic                   o_empty;
  logic                   o_almost_full;
  logic                   o_almost_empty;
  logic [ADDR_LENGTH:0]   o_level;

  modport slave (
    input  i_data_in, i_data_in_valid, i_ready_out,
    output o_ready_in, o_data_out, o_data_out_valid,
    output o_full, o_empty, o_almost_full, o_almost_empty, o_level
  );

  modport master (
    output i_data_in, i_data_in_valid, i_ready_out,
    input  o_ready_in, o_data_out, o_data_out_valid,
    input  o_full, o_empty, o_almost_full, o_almost_empty, o_level
  );
endinterface

// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO, 1 word/cycle, registered output and level flags.
// Optional synchronous flush port enabled by defining STREAM_FIFO_FLUSH_EN.
module stream_fifo #(
  parameter int ADDR_LENGTH         = 4,
  parameter int WORD_LENGTH         = 8,
  parameter int ALMOST_FULL_THRESH  = (2 ** ADDR_LENGTH) - 2,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  stream_fifo_if.slave      bus
`ifdef STREAM_FIFO_FLUSH_EN
  ,
  input  logic              i_flush
`endif
);

  localparam int                     DEPTH    = 2 ** ADDR_LENGTH;
  localparam int                     LVL_W    = ADDR_LENGTH + 1;
  localparam logic [LVL_W-1:0]       DEPTH_L  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]       AF_L     = LVL_W'(ALMOST_FULL_THRESH);
  localparam logic [LVL_W-1:0]       AE_L     = LVL_W'(ALMOST_EMPTY_THRESH);
  localparam logic [LVL_W-1:0]       LVL_ONE  = LVL_W'(1);
  localparam logic [ADDR_LENGTH-1:0] PTR_ONE  = ADDR_LENGTH'(1);

  if (ALMOST_FULL_THRESH < 0 || ALMOST_FULL_THRESH > DEPTH ||
      ALMOST_EMPTY_THRESH < 0 || ALMOST_EMPTY_THRESH > DEPTH) begin : g_bad_thresh
    $error("stream_fifo: almost-full/almost-empty threshold outside 0..DEPTH");
  end

  // Storage behind the output register; the output register counts toward o_level.
  logic [WORD_LENGTH-1:0] mem_q [DEPTH];
  logic                   mem_we;

  logic [ADDR_LENGTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d, mem_count;
  logic [WORD_LENGTH-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   full_q, full_d, empty_q, empty_d;
  logic                   afull_q, afull_d, aempty_q, aempty_d;
  logic                   ready_in, push, pop, flush;

`ifdef STREAM_FIFO_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  // Ready comes from registered state and reset only, never from i_ready_out.
  assign ready_in  = !full_q && !i_reset;
  assign push      = bus.i_data_in_valid && ready_in;
  assign pop       = valid_q && bus.i_ready_out;
  assign mem_count = level_q - {{ADDR_LENGTH{1'b0}}, valid_q};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    data_d   = data_q;
    valid_d  = valid_q;
    mem_we   = 1'b0;

    if (pop) begin
      if (mem_count != '0) begin
        data_d   = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        valid_d  = 1'b0;
      end
    end

    // A word bypasses storage when nothing is queued ahead of it in memory.
    if (push) begin
      if (!valid_q || (pop && mem_count == '0)) begin
        data_d  = bus.i_data_in;
        valid_d = 1'b1;
      end else begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
    end

    if (push && !pop)      level_d = level_q + LVL_ONE;
    else if (pop && !push) level_d = level_q - LVL_ONE;

    // Flush discards contents like reset but keeps the last output word visible.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      valid_d  = 1'b0;
      data_d   = data_q;
      mem_we   = 1'b0;
    end

    full_d   = (level_d == DEPTH_L);
    empty_d  = (level_d == '0);
    afull_d  = (level_d >= AF_L);
    aempty_d = (level_d <= AE_L);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  // NOTE: the storage array has no reset; the level and pointers define which entries are live.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= bus.i_data_in;
  end

  assign bus.o_ready_in       = ready_in;
  assign bus.o_data_out       = data_q;
  assign bus.o_data_out_valid = valid_q;
  assign bus.o_full           = full_q;
  assign bus.o_empty          = empty_q;
  assign bus.o_almost_full    = afull_q;
  assign bus.o_almost_empty   = aempty_q;
  assign bus.o_level          = level_q;

endmodule
